// File: rtl/rvh_l1d_entry_allocator.sv
// rvh_l1d_entry_allocator
//   Free-list allocator feeding the L1D age-order selector. Grants up to
//   ENQ_WIDTH free entry tags per cycle (lowest index first, in lane order),
//   reclaims tags on release, supports a full flush and reports occupancy.
//
//   Optional feature macro: RVH_L1D_ALLOC_DBL_FREE_CHK_EN
//     defined   : dbl_free_err_o pulses one cycle after a release of an
//                 already-free tag or a duplicate tag across release lanes;
//                 a consistency assertion ties the free count to the busy mask.
//     undefined : dbl_free_err_o is tied to 0 and no checker logic is built.

// One allocation lane: picks the lowest available entry and removes it from
// the availability mask handed to the next lane.
module rvh_l1d_entry_allocator_lane #(
    parameter int ENTRY_COUNT = 4,
    parameter int ENTRY_TAG   = 2
) (
    input  logic                   en,
    input  logic                   req,
    input  logic                   prior_ok,
    input  logic [ENTRY_COUNT-1:0] avail_in,
    output logic                   gnt,
    output logic [ENTRY_TAG-1:0]   tag,
    output logic [ENTRY_COUNT-1:0] avail_out
);

    logic [ENTRY_COUNT-1:0] lowest;
    logic                   found;

    // Priority-encode the lowest available entry into a one-hot and a tag.
    always_comb begin
        lowest = '0;
        tag    = '0;
        found  = 1'b0;
        for (int e = 0; e < ENTRY_COUNT; e++) begin
            if (avail_in[e] && !found) begin
                lowest[e] = 1'b1;
                tag       = ENTRY_TAG'(e);
                found     = 1'b1;
            end
        end
    end

    assign gnt       = en & req & prior_ok & found;
    assign avail_out = gnt ? (avail_in & ~lowest) : avail_in;

endmodule

module rvh_l1d_entry_allocator #(
    parameter  int ENTRY_COUNT = 4,
    parameter  int ENQ_WIDTH   = 1,
    parameter  int DEQ_WIDTH   = 1,
    localparam int ENTRY_TAG   = $clog2(ENTRY_COUNT),
    localparam int CNT_W       = $clog2(ENTRY_COUNT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ENQ_WIDTH-1:0]           alloc_req_i,
    output logic [ENQ_WIDTH-1:0]           alloc_gnt_o,
    output logic [ENQ_WIDTH*ENTRY_TAG-1:0] alloc_tag_o,
    output logic [ENQ_WIDTH-1:0]           enq_vld_o,
    output logic [ENQ_WIDTH*ENTRY_TAG-1:0] enq_tag_o,
    input  logic [DEQ_WIDTH-1:0]           rel_vld_i,
    input  logic [DEQ_WIDTH*ENTRY_TAG-1:0] rel_tag_i,
    input  logic                           flush_i,
    output logic [ENTRY_COUNT-1:0]         busy_mask_o,
    output logic [CNT_W-1:0]               free_cnt_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           dbl_free_err_o
);

    logic [ENTRY_COUNT-1:0] busy_r;
    logic [ENTRY_COUNT-1:0] busy_n;
    logic [CNT_W-1:0]       free_cnt_r;
    logic [ENTRY_COUNT-1:0] gnt_oh;
    logic [ENTRY_COUNT-1:0] rel_oh;
    logic                   lane_en;

    // Lane chain: availability mask and "all earlier requesters granted"
    // flag ripple from lane 0 upward. Unpacked so each stage is a distinct net.
    logic [ENTRY_COUNT-1:0] avail_c [ENQ_WIDTH+1];
    logic                   ok_c    [ENQ_WIDTH];
    logic                   gnt_c   [ENQ_WIDTH];

    function automatic logic [CNT_W-1:0] count_free(input logic [ENTRY_COUNT-1:0] busy);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int e = 0; e < ENTRY_COUNT; e++) begin
            if (!busy[e]) c = c + CNT_W'(1);
        end
        return c;
    endfunction

    // No grants during reset or flush; full needs no gating since no entry is available.
    assign lane_en    = rst_n & ~flush_i;
    assign avail_c[0] = ~busy_r;

    for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_lane
        if (i == 0) begin : g_first
            assign ok_c[i] = 1'b1;
        end else begin : g_rest
            // A requesting lane that was refused blocks every later lane.
            assign ok_c[i] = ok_c[i-1] & (~alloc_req_i[i-1] | gnt_c[i-1]);
        end

        rvh_l1d_entry_allocator_lane #(
            .ENTRY_COUNT (ENTRY_COUNT),
            .ENTRY_TAG   (ENTRY_TAG)
        ) u_lane (
            .en        (lane_en),
            .req       (alloc_req_i[i]),
            .prior_ok  (ok_c[i]),
            .avail_in  (avail_c[i]),
            .gnt       (gnt_c[i]),
            .tag       (alloc_tag_o[i*ENTRY_TAG +: ENTRY_TAG]),
            .avail_out (avail_c[i+1])
        );

        assign alloc_gnt_o[i] = gnt_c[i];
    end

    assign enq_vld_o = alloc_gnt_o;
    assign enq_tag_o = alloc_tag_o;

    // Entries consumed by the lanes are exactly those dropped from the mask.
    assign gnt_oh = avail_c[0] & ~avail_c[ENQ_WIDTH];

    // Release one-hot; duplicate tags across lanes simply OR together.
    always_comb begin
        rel_oh = '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                if (rel_vld_i[j] && rel_tag_i[j*ENTRY_TAG +: ENTRY_TAG] == ENTRY_TAG'(e))
                    rel_oh[e] = 1'b1;
            end
        end
    end

    // Next occupancy: flush clears everything and wins over same-cycle release.
    always_comb begin
        busy_n = (busy_r | gnt_oh) & ~rel_oh;
        if (flush_i) busy_n = '0;
    end

    // Occupancy state; the count is recomputed from the next mask so it cannot drift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= '0;
            free_cnt_r <= CNT_W'(ENTRY_COUNT);
        end else begin
            busy_r     <= busy_n;
            free_cnt_r <= count_free(busy_n);
        end
    end

    assign busy_mask_o = busy_r;
    assign free_cnt_o  = free_cnt_r;
    assign full_o      = (free_cnt_r == '0);
    assign empty_o     = (free_cnt_r == CNT_W'(ENTRY_COUNT));

`ifdef RVH_L1D_ALLOC_DBL_FREE_CHK_EN
    logic err_n;
    logic err_r;

    // Flag releases of free entries and same-tag duplicates; ignored on flush.
    always_comb begin
        err_n = 1'b0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                if (rel_vld_i[j] && !busy_r[e] &&
                    rel_tag_i[j*ENTRY_TAG +: ENTRY_TAG] == ENTRY_TAG'(e))
                    err_n = 1'b1;
            end
            for (int k = j + 1; k < DEQ_WIDTH; k++) begin
                if (rel_vld_i[j] && rel_vld_i[k] &&
                    rel_tag_i[j*ENTRY_TAG +: ENTRY_TAG] == rel_tag_i[k*ENTRY_TAG +: ENTRY_TAG])
                    err_n = 1'b1;
            end
        end
        if (flush_i) err_n = 1'b0;
    end

    // One-cycle error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) err_r <= 1'b0;
        else        err_r <= err_n;
    end

    // Free count must always equal the number of clear busy bits.
    always_ff @(posedge clk) begin
        if (rst_n) assert (count_free(busy_r) == free_cnt_r);
    end

    assign dbl_free_err_o = err_r;
`else
    assign dbl_free_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvh_l1d_entry_allocator.sv
// Randomized + directed bench for rvh_l1d_entry_allocator (4 entries, 2 lanes
// each way) against a free-list reference model.
module tb_rvh_l1d_entry_allocator;

    localparam int EC = 4;
    localparam int EW = 2;
    localparam int DW = 2;
    localparam int ET = 2;
    localparam int CW = 3;
`ifdef RVH_L1D_ALLOC_DBL_FREE_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [EW-1:0]    alloc_req_i;
    logic [EW-1:0]    alloc_gnt_o;
    logic [EW*ET-1:0] alloc_tag_o;
    logic [EW-1:0]    enq_vld_o;
    logic [EW*ET-1:0] enq_tag_o;
    logic [DW-1:0]    rel_vld_i;
    logic [DW*ET-1:0] rel_tag_i;
    logic             flush_i;
    logic [EC-1:0]    busy_mask_o;
    logic [CW-1:0]    free_cnt_o;
    logic             full_o;
    logic             empty_o;
    logic             dbl_free_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one flag per entry plus the pending error pulse.
    bit mb [EC];
    bit merr;

    always #5 clk = ~clk;

    rvh_l1d_entry_allocator #(
        .ENTRY_COUNT (EC),
        .ENQ_WIDTH   (EW),
        .DEQ_WIDTH   (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_req_i    (alloc_req_i),
        .alloc_gnt_o    (alloc_gnt_o),
        .alloc_tag_o    (alloc_tag_o),
        .enq_vld_o      (enq_vld_o),
        .enq_tag_o      (enq_tag_o),
        .rel_vld_i      (rel_vld_i),
        .rel_tag_i      (rel_tag_i),
        .flush_i        (flush_i),
        .busy_mask_o    (busy_mask_o),
        .free_cnt_o     (free_cnt_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .dbl_free_err_o (dbl_free_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs against the model, advance the model.
    task automatic cyc(input logic [1:0] req, input logic [1:0] rv, input logic [1:0] t0,
                       input logic [1:0] t1, input logic fl, input logic rs);
        int       freeq[$];
        int       nfree;
        bit       stall;
        bit       nerr;
        bit       nb [EC];
        logic [1:0] eg;
        logic [1:0] et [EW];
        logic [1:0] rt [DW];
        logic [EC-1:0] bm;

        @(negedge clk);
        alloc_req_i = req;
        rel_vld_i   = rv;
        rel_tag_i   = {t1, t0};
        flush_i     = fl;
        rst_n       = rs;
        #1;

        bm = '0;
        nfree = 0;
        for (int e = 0; e < EC; e++) begin
            bm[e] = mb[e];
            if (!mb[e]) nfree++;
        end
        chk("busy_mask", 32'(busy_mask_o), 32'(bm));
        chk("free_cnt",  32'(free_cnt_o),  32'(nfree));
        chk("full",      32'(full_o),      32'(nfree == 0));
        chk("empty",     32'(empty_o),     32'(nfree == EC));
        chk("dbl_err",   32'(dbl_free_err_o), 32'(CHK_EN & merr));

        // Free list in ascending order; lanes take from the front in order.
        for (int e = 0; e < EC; e++) if (!mb[e]) freeq.push_back(e);
        eg = '0;
        stall = 1'b0;
        for (int l = 0; l < EW; l++) begin
            et[l] = '0;
            if (req[l]) begin
                if (!stall && rs && !fl && freeq.size() > 0) begin
                    eg[l] = 1'b1;
                    et[l] = 2'(freeq.pop_front());
                end else begin
                    stall = 1'b1;
                end
            end
        end
        chk("gnt",     32'(alloc_gnt_o), 32'(eg));
        chk("enq_vld", 32'(enq_vld_o),   32'(eg));
        for (int l = 0; l < EW; l++) begin
            if (eg[l]) begin
                chk("alloc_tag", 32'(alloc_tag_o[l*ET +: ET]), 32'(et[l]));
                chk("enq_tag",   32'(enq_tag_o[l*ET +: ET]),   32'(et[l]));
            end
        end

        nb = mb;
        nerr = 1'b0;
        rt[0] = t0;
        rt[1] = t1;
        if (!rs || fl) begin
            for (int e = 0; e < EC; e++) nb[e] = 1'b0;
        end else begin
            for (int l = 0; l < EW; l++) if (eg[l]) nb[et[l]] = 1'b1;
            for (int j = 0; j < DW; j++) begin
                if (rv[j]) begin
                    if (!mb[rt[j]]) nerr = 1'b1;
                    nb[rt[j]] = 1'b0;
                end
            end
            if (rv == 2'b11 && t0 == t1) nerr = 1'b1;
        end

        @(posedge clk);
        mb = nb;
        merr = nerr;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_req_i = '0;
        rel_vld_i = '0;
        rel_tag_i = '0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        for (int e = 0; e < EC; e++) mb[e] = 1'b0;
        merr = 1'b0;

        // Fill one entry at a time: tags 0..3, then refused while full.
        repeat (4) cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        chk("t1_full", 32'(full_o), 32'd1);

        // Released tag is not reusable until the next cycle.
        cyc(2'b01, 2'b01, 2'd2, 2'd0, 1'b0, 1'b1);
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);

        // Flush while full with requests pending.
        cyc(2'b11, 2'b00, 2'd0, 2'd0, 1'b1, 1'b1);
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);

        // Two lanes over a holey mask, then lane1-only on an empty pool.
        cyc(2'b11, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b01, 2'd1, 2'd0, 1'b0, 1'b1);
        cyc(2'b11, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b1, 1'b1);
        cyc(2'b10, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);

        // Double free and duplicate-lane release.
        cyc(2'b00, 2'b01, 2'd1, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b11, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);

        // Reset in the middle of traffic.
        cyc(2'b11, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b11, 2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        chk("t6_empty", 32'(empty_o), 32'd1);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            cyc(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
